alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Controls the alarm clock's ring and snooze sequence. Compares the running time (HH:MM:SS)
//  from the timekeeping counter against the programmed alarm time, then steps through
//  ring, snooze and timeout. Sits between the time/alarm registers and the buzzer output.
//  Advances only on the 1 Hz tick strobe; all state is clocked on clk.
// PARAMETERS
//  SNOOZE_SEC   300  snooze length in seconds (>=1)
//  RING_SEC     60   ring length in seconds before auto-stop (>=1)
//  MAX_SNOOZE   3    number of snoozes allowed per alarm event (0 = snooze disabled)
//  TW           $clog2(max(SNOOZE_SEC,RING_SEC)+1)  seconds-timer width (derived, localparam)
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst_n        in   1   synchronous reset, active low
//  tick_1hz     in   1   single-cycle pulse, once per second, coincident with time update
//  cur_h        in   5   current hour, 0..23
//  cur_m        in   6   current minute, 0..59
//  cur_s        in   6   current second, 0..59
//  al_h         in   5   alarm hour, 0..23
//  al_m         in   6   alarm minute, 0..59
//  alarm_en     in   1   level: alarm armed when high
//  snooze_btn   in   1   debounced level; acted on at rising edge
//  stop_btn     in   1   debounced level; acted on at rising edge
//  ring         out  1   buzzer enable
//  snoozing     out  1   high while in SNOOZE
//  snooze_cnt   out  2+  snoozes used this event; width $clog2(MAX_SNOOZE+1), min 1
//  missed       out  1   one-cycle pulse when ring times out with no user action
//  remain_s     out  TW  seconds left in the current RINGING/SNOOZE phase, 0 otherwise
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=DISARMED, all outputs 0, timer 0, button edge regs 0.
//  Button edge: press = btn & ~btn_q (btn_q registered). A held button acts once.
//  match = tick_1hz & cur_h==al_h & cur_m==al_m & cur_s==0. Fires once per day.
//  States and transitions (all registered; outputs change the cycle after the cause):
//   DISARMED: alarm_en=1 -> ARMED.
//   ARMED:    match -> RINGING, timer<=RING_SEC, snooze_cnt<=0.
//   RINGING:  ring=1. Priority stop > snooze > timeout:
//             stop press -> ARMED, snooze_cnt<=0.
//             snooze press & snooze_cnt<MAX_SNOOZE -> SNOOZE, timer<=SNOOZE_SEC, snooze_cnt+1.
//             snooze press & snooze_cnt==MAX_SNOOZE -> ignored, keep ringing.
//             tick_1hz & timer==1 -> ARMED, missed pulses 1 cycle, snooze_cnt<=0.
//             tick_1hz & timer>1 -> timer-1.
//   SNOOZE:   snoozing=1, ring=0. stop press -> ARMED, snooze_cnt<=0.
//             tick_1hz & timer==1 -> RINGING, timer<=RING_SEC. Snooze presses ignored.
//  alarm_en=0 in any state beats every other event -> DISARMED next cycle.
//   ring/snoozing drop, timer and snooze_cnt clear, missed not pulsed.
//  match in RINGING/SNOOZE is ignored (no restart).
//  A tick and a stop press in the same cycle: stop wins, timer not decremented.
//  Alarm time changed mid-event: current event proceeds unaffected.
//  remain_s = timer in RINGING/SNOOZE, else 0. Timer never wraps below 1 in active states.
//  Reset mid-ring: outputs are 0 the cycle after the reset edge. Alarm re-arms only after
//   alarm_en is seen high.
// TESTING (SNOOZE_SEC=3, RING_SEC=4, MAX_SNOOZE=2, tick every 10 clk)
//  1 Arm 07:30. Drive time 07:29:59 -> 07:30:00 on tick -> ring=1 the next cycle, remain_s=4.
//  2 Ring with no input -> ring=1 for exactly 4 ticks, then missed pulses for 1 cycle,
//    ring=0, state ARMED.
//  3 Ring, snooze press -> snoozing=1, snooze_cnt=1. After 3 ticks ring=1 again.
//    Snooze -> cnt=2. Third snooze press is ignored and ring stays 1.
//  4 Stop press while ringing, and also while snoozing -> ring=0, snoozing=0,
//    snooze_cnt=0 next cycle. Hold stop for 50 clk -> a single action only.
//  5 Drop alarm_en during RINGING, same cycle as tick and snooze press -> DISARMED,
//    all outputs 0, missed=0.
//  6 Assert rst_n=0 for 1 clk mid-SNOOZE -> all outputs 0. With alarm_en=0,
//    a time match does nothing. Then alarm_en=1 -> next match rings.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze sequencer: compares running time against the alarm time and
// steps through ring, snooze and timeout on the 1 Hz tick.
module alarm_sequencer #(
  parameter  int unsigned SNOOZE_SEC = 300,
  parameter  int unsigned RING_SEC   = 60,
  parameter  int unsigned MAX_SNOOZE = 3,
  localparam int unsigned TW = $clog2(((SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC) + 1),
  localparam int unsigned CW = (MAX_SNOOZE == 0) ? 1 : $clog2(MAX_SNOOZE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_1hz,
  input  logic [4:0]    cur_h,
  input  logic [5:0]    cur_m,
  input  logic [5:0]    cur_s,
  input  logic [4:0]    al_h,
  input  logic [5:0]    al_m,
  input  logic          alarm_en,
  input  logic          snooze_btn,
  input  logic          stop_btn,
  output logic          ring,
  output logic          snoozing,
  output logic [CW-1:0] snooze_cnt,
  output logic          missed,
  output logic [TW-1:0] remain_s
);

  typedef enum logic [1:0] {
    DISARMED,
    ARMED,
    RINGING,
    SNOOZE
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          missed_q, missed_nx;
  logic          snooze_q, stop_q;
  logic          snooze_press, stop_press, match, can_snooze, timer_more;

  assign snooze_press = snooze_btn & ~snooze_q;
  assign stop_press   = stop_btn & ~stop_q;
  assign match        = tick_1hz & (cur_h == al_h) & (cur_m == al_m) & (cur_s == '0);
  assign can_snooze   = 32'(cnt) < MAX_SNOOZE;
  assign timer_more   = timer > TW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DISARMED;
      timer    <= '0;
      cnt      <= '0;
      missed_q <= 1'b0;
      snooze_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      cnt      <= cnt_nx;
      missed_q <= missed_nx;
      snooze_q <= snooze_btn;
      stop_q   <= stop_btn;
    end
  end

  // Disarm overrides everything; within RINGING the order is stop, snooze, tick.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    cnt_nx    = cnt;
    missed_nx = 1'b0;
    if (!alarm_en) begin
      state_nx = DISARMED;
      timer_nx = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        DISARMED: state_nx = ARMED;
        ARMED: begin
          if (match) begin
            state_nx = RINGING;
            timer_nx = TW'(RING_SEC);
            cnt_nx   = '0;
          end
        end
        RINGING: begin
          if (stop_press) begin
            state_nx = ARMED;
            timer_nx = '0;
            cnt_nx   = '0;
          end else if (snooze_press && can_snooze) begin
            state_nx = SNOOZE;
            timer_nx = TW'(SNOOZE_SEC);
            cnt_nx   = cnt + CW'(1);
          end else if (tick_1hz) begin
            if (timer_more) begin
              timer_nx = timer - TW'(1);
            end else begin
              state_nx  = ARMED;
              timer_nx  = '0;
              cnt_nx    = '0;
              missed_nx = 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop_press) begin
            state_nx = ARMED;
            timer_nx = '0;
            cnt_nx   = '0;
          end else if (tick_1hz) begin
            if (timer_more) begin
              timer_nx = timer - TW'(1);
            end else begin
              state_nx = RINGING;
              timer_nx = TW'(RING_SEC);
            end
          end
        end
        default: begin
          state_nx = DISARMED;
          timer_nx = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign ring       = (state == RINGING);
  assign snoozing   = (state == SNOOZE);
  assign snooze_cnt = cnt;
  assign missed     = missed_q;
  assign remain_s   = (ring | snoozing) ? timer : '0;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, alarm_en, snooze_btn, stop_btn;
  logic [4:0] cur_h, al_h;
  logic [5:0] cur_m, cur_s, al_m;
  logic       ring, snoozing, missed;
  logic [1:0] snooze_cnt;
  logic [2:0] remain_s;

  typedef struct {
    string      name;
    logic       ring;
    logic       snoozing;
    logic [1:0] cnt;
    logic       missed;
    logic [2:0] remain;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   missed_seen = 0;

  alarm_sequencer #(
    .SNOOZE_SEC(3),
    .RING_SEC  (4),
    .MAX_SNOOZE(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .cur_h     (cur_h),
    .cur_m     (cur_m),
    .cur_s     (cur_s),
    .al_h      (al_h),
    .al_m      (al_m),
    .alarm_en  (alarm_en),
    .snooze_btn(snooze_btn),
    .stop_btn  (stop_btn),
    .ring      (ring),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt),
    .missed    (missed),
    .remain_s  (remain_s)
  );

  always #5 clk = ~clk;

  // Monitor: compare one queued expectation per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (missed === 1'b1) missed_seen++;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if ({ring, snoozing, snooze_cnt, missed, remain_s} !==
            {mon_e.ring, mon_e.snoozing, mon_e.cnt, mon_e.missed, mon_e.remain}) begin
          errors++;
          $display("FAIL %s: got ring=%b snoozing=%b cnt=%0d missed=%b remain=%0d, expected ring=%b snoozing=%b cnt=%0d missed=%b remain=%0d",
                   mon_e.name, ring, snoozing, snooze_cnt, missed, remain_s,
                   mon_e.ring, mon_e.snoozing, mon_e.cnt, mon_e.missed, mon_e.remain);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string name, input logic r, input logic s,
                         input logic [1:0] c, input logic m, input logic [2:0] rem);
    exp_t e;
    e.name = name; e.ring = r; e.snoozing = s; e.cnt = c; e.missed = m; e.remain = rem;
    sb.push_back(e);
  endtask

  // Nine idle clocks, then a one-cycle tick carrying the new time.
  task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    repeat (9) step();
    cur_h = h; cur_m = m; cur_s = s;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cur_h = 5'd7; cur_m = 6'd0; cur_s = 6'd0; al_h = 5'd7; al_m = 6'd30;
    step(); step();
    exp_out("reset", 0, 0, 0, 0, 0);

    // 1: arm and match
    rst_n = 1'b1; alarm_en = 1'b1;
    step();                      exp_out("armed_idle", 0, 0, 0, 0, 0);
    tick_at(7, 29, 59);          exp_out("pre_match", 0, 0, 0, 0, 0);
    tick_at(7, 30, 0);           exp_out("match_ring", 1, 0, 0, 0, 4);

    // 2: timeout with no user action
    tick_at(7, 30, 1);           exp_out("ring_t1", 1, 0, 0, 0, 3);
    tick_at(7, 30, 2);           exp_out("ring_t2", 1, 0, 0, 0, 2);
    tick_at(7, 30, 3);           exp_out("ring_t3", 1, 0, 0, 0, 1);
    tick_at(7, 30, 4);           exp_out("timeout_missed", 0, 0, 0, 1, 0);
    step();                      exp_out("missed_one_cycle", 0, 0, 0, 0, 0);

    // 3: snooze sequence and limit; alarm time changed mid-event
    al_m = 6'd31;
    tick_at(7, 31, 0);           exp_out("ring2", 1, 0, 0, 0, 4);
    snooze_btn = 1'b1; step();   exp_out("snooze1", 0, 1, 1, 0, 3);
    snooze_btn = 1'b0; al_m = 6'd59;
    step();                      exp_out("al_change", 0, 1, 1, 0, 3);
    tick_at(7, 31, 1);           exp_out("snz_t1", 0, 1, 1, 0, 2);
    tick_at(7, 31, 2);           exp_out("snz_t2", 0, 1, 1, 0, 1);
    tick_at(7, 31, 3);           exp_out("resume_ring", 1, 0, 1, 0, 4);
    snooze_btn = 1'b1; step();   exp_out("snooze2", 0, 1, 2, 0, 3);
    snooze_btn = 1'b0; step();
    tick_at(7, 31, 4);
    tick_at(7, 31, 5);
    tick_at(7, 31, 6);           exp_out("resume_ring2", 1, 0, 2, 0, 4);
    snooze_btn = 1'b1; step();   exp_out("snooze_limit", 1, 0, 2, 0, 4);
    snooze_btn = 1'b0; step();
    tick_at(7, 59, 0);           exp_out("match_in_ring", 1, 0, 2, 0, 3);

    // 4: stop while ringing, held stop acts once, stop while snoozing with tick
    stop_btn = 1'b1; step();     exp_out("stop_ring", 0, 0, 0, 0, 0);
    repeat (49) step();
    al_m = 6'd32;
    tick_at(7, 32, 0);           exp_out("held_stop_once", 1, 0, 0, 0, 4);
    snooze_btn = 1'b1; step();   exp_out("snooze_stop_held", 0, 1, 1, 0, 3);
    snooze_btn = 1'b0; stop_btn = 1'b0; step();
    repeat (9) step();
    cur_s = 6'd1; tick_1hz = 1'b1; stop_btn = 1'b1;
    step();                      exp_out("stop_snooze_tick", 0, 0, 0, 0, 0);
    tick_1hz = 1'b0; stop_btn = 1'b0;

    // 5: disarm beats tick and snooze press
    al_m = 6'd33;
    tick_at(7, 33, 0);           exp_out("ring3", 1, 0, 0, 0, 4);
    tick_at(7, 33, 1);
    tick_at(7, 33, 2);
    tick_at(7, 33, 3);           exp_out("ring_rem1", 1, 0, 0, 0, 1);
    repeat (9) step();
    cur_s = 6'd4; tick_1hz = 1'b1; snooze_btn = 1'b1; alarm_en = 1'b0;
    step();                      exp_out("disarm_priority", 0, 0, 0, 0, 0);
    tick_1hz = 1'b0; snooze_btn = 1'b0;
    step();                      exp_out("disarm_hold", 0, 0, 0, 0, 0);

    // 6: reset mid-snooze, no ring while disabled, re-arm
    alarm_en = 1'b1; step();
    al_m = 6'd34;
    tick_at(7, 34, 0);           exp_out("ring4", 1, 0, 0, 0, 4);
    snooze_btn = 1'b1; step();   exp_out("snooze4", 0, 1, 1, 0, 3);
    snooze_btn = 1'b0; rst_n = 1'b0; alarm_en = 1'b0;
    step();                      exp_out("reset_mid_snooze", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick_at(7, 34, 0);           exp_out("no_ring_disabled", 0, 0, 0, 0, 0);
    alarm_en = 1'b1; step();     exp_out("rearmed_idle", 0, 0, 0, 0, 0);
    al_m = 6'd35;
    tick_at(7, 35, 0);           exp_out("rearm_ring", 1, 0, 0, 0, 4);

    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    checks++;
    if (missed_seen != 1) begin
      errors++;
      $display("FAIL missed_total: got %0d missed cycles, expected 1", missed_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
